alu_result_fifo: RTL and testbench

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_result_fifo.sv | 71 +++++++
 tb/tb_alu_result_fifo.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU result definitions: flag bit positions and result-entry sizing.
package alu_pkg;

  localparam int FLAG_W      = 5;
  localparam int FLAG_SIGN   = 4;
  localparam int FLAG_ZERO   = 3;
  localparam int FLAG_CARRY  = 2;
  localparam int FLAG_PARITY = 1;
  localparam int FLAG_OVF    = 0;

  localparam int ALU_DATA_W  = 16;
  localparam int ENTRY_W     = ALU_DATA_W + FLAG_W;

  // Stored word width for a given result width: {z, flags}.
  function automatic int entry_w(input int data_w);
    return data_w + FLAG_W;
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Ready/valid FIFO buffering ALU {Z, flags} results, with sticky overflow/carry status.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_z,
  input  logic [FLAG_W-1:0]          in_flags,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_z,
  output logic [FLAG_W-1:0]          out_flags,
  input  logic                       out_ready,
  input  logic                       clr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       sticky_ovf,
  output logic                       sticky_carry
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int EW    = entry_w(DATA_W);

  logic [EW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic             push, pop;

  assign in_ready  = (count < CNT_W'(DEPTH)) || out_ready;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head is read straight from storage; a fresh push is never bypassed to the output.
  assign {out_z, out_flags} = mem[rptr];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wptr] <= {in_z, in_flags};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      sticky_ovf   <= 1'b0;
      sticky_carry <= 1'b0;
    end else if (clr) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      sticky_ovf   <= 1'b0;
      sticky_carry <= 1'b0;
    end else begin
      if (push) begin
        wptr         <= wptr + PTR_W'(1);
        sticky_ovf   <= sticky_ovf   | in_flags[FLAG_OVF];
        sticky_carry <= sticky_carry | in_flags[FLAG_CARRY];
      end
      if (pop) rptr <= rptr + PTR_W'(1);
      // Full is judged from count, so a simultaneous push+pop at DEPTH leaves it unchanged.
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomized plus directed check of alu_result_fifo against a queue-based model.
module tb_alu_result_fifo;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, out_ready, clr;
  logic [DATA_W-1:0] in_z;
  logic [4:0]        in_flags;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] out_z;
  logic [4:0]        out_flags;
  logic [2:0]        count;
  logic              sticky_ovf, sticky_carry;

  alu_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_z(in_z), .in_flags(in_flags),
    .in_ready(in_ready), .out_valid(out_valid), .out_z(out_z), .out_flags(out_flags),
    .out_ready(out_ready), .clr(clr), .count(count),
    .sticky_ovf(sticky_ovf), .sticky_carry(sticky_carry)
  );

  always #5 clk = ~clk;

  logic [20:0] mq[$];
  logic        m_ovf, m_carry;
  int          vec_cnt = 0;
  int          err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_ovf   = 1'b0;
    m_carry = 1'b0;
  endtask

  task automatic check_state();
    chk("count", 32'(count), 32'(mq.size()));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_z", 32'(out_z), 32'(mq[0][20:5]));
      chk("out_flags", 32'(out_flags), 32'(mq[0][4:0]));
    end
    chk("sticky_ovf", 32'(sticky_ovf), 32'(m_ovf));
    chk("sticky_carry", 32'(sticky_carry), 32'(m_carry));
  endtask

  // Called just after a falling edge: drive, check in_ready, clock, update model, check.
  task automatic cycle(input logic v, input logic [15:0] z, input logic [4:0] f,
                       input logic r, input logic c);
    bit can_push, can_pop;
    in_valid = v; in_z = z; in_flags = f; out_ready = r; clr = c;
    #1;
    chk("in_ready", 32'(in_ready), 32'((mq.size() < DEPTH) || r));
    can_push = v && ((mq.size() < DEPTH) || r);
    can_pop  = r && (mq.size() != 0);
    @(posedge clk);
    if (c) model_clear();
    else begin
      if (can_pop) void'(mq.pop_front());
      if (can_push) begin
        mq.push_back({z, f});
        m_ovf   |= f[0];
        m_carry |= f[2];
      end
    end
    @(negedge clk);
    check_state();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_z = '0; in_flags = '0; out_ready = 1'b0; clr = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("in_ready_in_reset", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    #1;
    check_state();
  endtask

  initial begin
    do_reset();

    // Single push, visible after one edge
    cycle(1, 16'h7FFF, 5'b00000, 0, 0);
    cycle(0, 16'h0, 5'b0, 1, 0);

    // Fill, refuse a fifth, drain in order
    for (int i = 1; i <= 4; i++) cycle(1, 16'(i), 5'b0, 0, 0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    cycle(1, 16'h0005, 5'b0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 16'h0, 5'b0, 1, 0);
    cycle(0, 16'h0, 5'b0, 1, 0);  // pop when empty

    // Full FIFO streaming push+pop; pointers wrap
    for (int i = 1; i <= 4; i++) cycle(1, 16'(16'h10 + i), 5'b0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1, 16'(16'h20 + i), 5'b00100 * 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 16'h0, 5'b0, 1, 0);

    // Sticky overflow then carry
    cycle(1, 16'h8000, 5'b10001, 0, 0);
    cycle(1, 16'h1234, 5'b00000, 1, 0);
    cycle(1, 16'h0042, 5'b00010, 1, 0);
    chk("sticky_ovf_held", 32'(sticky_ovf), 32'd1);
    chk("sticky_carry_clean", 32'(sticky_carry), 32'd0);
    cycle(1, 16'h0000, 5'b01110, 1, 0);
    chk("sticky_carry_set", 32'(sticky_carry), 32'd1);

    // clr wins over push+pop at count=3
    cycle(0, 16'h0, 5'b0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 16'(16'h30 + i), 5'b00101, 0, 0);
    cycle(1, 16'hBEEF, 5'b00101, 1, 1);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_sticky", 32'({sticky_ovf, sticky_carry}), 32'd0);

    // Async reset between edges with count=2
    cycle(1, 16'hAAAA, 5'b0, 0, 0);
    cycle(1, 16'h5555, 5'b0, 0, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_out_valid", 32'(out_valid), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 16'h0ACE, 5'b0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), 16'($urandom), 5'($urandom),
            1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
